// File: rtl/parity_frame_pkg.sv
// Shared types and helpers for the serial parity link receiver.
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // XOR of the low n bits of v.
    function automatic logic parity_of(logic [31:0] v, int n);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (int'(i) < n) p ^= v[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/parity_frame_rx_xor_accum.sv
// One-bit registered XOR accumulator; clr has priority over en.
module xor_accum (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    // Running XOR of every bit presented while en is high.
    always_ff @(posedge clk) begin
        if (rst || clr) q <= 1'b0;
        else if (en)    q <= q ^ d;
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, parity, stop.
// Received words are presented through a one-entry valid/ready holding register.
module parity_frame_rx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int   CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic ODD = (PARITY_ODD != 0);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              perr_q;
    logic              acc_q;

    logic acc_clr, acc_en, start_take, data_take, par_take, complete, load;

    xor_accum u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .d   (bit_in),
        .q   (acc_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-strobe datapath controls; nothing moves without bit_valid.
    always_comb begin
        state_d    = state_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        start_take = 1'b0;
        data_take  = 1'b0;
        par_take   = 1'b0;
        complete   = 1'b0;
        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d    = DATA;
                        acc_clr    = 1'b1;
                        start_take = 1'b1;
                    end
                end
                DATA: begin
                    data_take = 1'b1;
                    acc_en    = 1'b1;
                    if (cnt_q == LAST) state_d = PARITY;
                end
                PARITY: begin
                    par_take = 1'b1;
                    state_d  = STOP;
                end
                STOP: begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign load = complete && (!out_valid || out_ready);

    // Frame datapath: bit counter, LSB-first shift register, captured parity result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            if (start_take) cnt_q <= '0;
            if (data_take) begin
                shift_q[cnt_q] <= bit_in;
                if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
            end
            if (par_take) perr_q <= acc_q ^ bit_in ^ ODD;
        end
    end

    // Holding register: accept a completed frame when empty or draining, else flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            if (load) begin
                out_data   <= shift_q;
                parity_err <= perr_q;
                frame_err  <= ~bit_in;
                out_valid  <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomised bench for parity_frame_rx against a frame-level reference model.
module tb_parity_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, bit_valid, bit_in, out_ready;
    logic [7:0] out_data, o_data;
    logic       out_valid, parity_err, frame_err, overrun, busy;
    logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_data(o_data), .out_valid(o_valid), .out_ready(out_ready),
        .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr), .busy(o_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents of the holding register and frame activity.
    bit       m_valid, m_pe, m_pe_odd, m_fe, m_ovr, m_busy;
    bit [7:0] m_data;
    bit [7:0] f_data;
    bit       f_pe, f_pe_odd, f_fe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("overrun",   32'(overrun),   32'(m_ovr));
        check("busy",      32'(busy),      32'(m_busy));
        check("odd_valid", 32'(o_valid),   32'(m_valid));
        if (m_valid) begin
            check("out_data",   32'(out_data),   32'(m_data));
            check("parity_err", 32'(parity_err), 32'(m_pe));
            check("frame_err",  32'(frame_err),  32'(m_fe));
            check("odd_perr",   32'(o_perr),     32'(m_pe_odd));
        end
    endtask

    function automatic bit pick_rdy(input int mode);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return bit'(mode);
    endfunction

    // One clock with the given inputs, then advance the model and compare.
    task automatic step(input bit bv, input bit bi, input bit rdy, input bit is_stop, input bit busy_after);
        bit_valid = bv;
        bit_in    = bi;
        out_ready = rdy;
        @(posedge clk);
        if (is_stop) begin
            if (!m_valid || rdy) begin
                m_valid  = 1'b1;
                m_data   = f_data;
                m_pe     = f_pe;
                m_pe_odd = f_pe_odd;
                m_fe     = f_fe;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_busy = busy_after;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_valid = 1'($urandom);
        bit_in    = 1'($urandom);
        out_ready = 1'($urandom);
        @(posedge clk);
        m_valid = 0; m_ovr = 0; m_busy = 0;
        #1;
        rst = 1'b0;
        check_outputs();
        check("rst_data", 32'(out_data),   32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err),  32'd0);
    endtask

    task automatic gap(input int gmax, input int rmode, input bit busy_now);
        int n;
        n = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        repeat (n) step(1'b0, 1'($urandom), pick_rdy(rmode), 1'b0, busy_now);
    endtask

    // Sends a complete frame; abort_at>0 resets after that many data bits.
    task automatic send_frame(input bit [7:0] d, input bit pbit, input bit sbit, input int gmax,
                              input int rmode, input int rstop, input int abort_at);
        gap(gmax, rmode, 1'b0);
        step(1'b1, 1'b0, pick_rdy(rmode), 1'b0, 1'b1);
        for (int unsigned i = 0; i < 8; i++) begin
            gap(gmax, rmode, 1'b1);
            step(1'b1, d[i], pick_rdy(rmode), 1'b0, 1'b1);
            if (int'(i) + 1 == abort_at) begin
                do_reset();
                return;
            end
        end
        gap(gmax, rmode, 1'b1);
        step(1'b1, pbit, pick_rdy(rmode), 1'b0, 1'b1);
        f_data   = d;
        f_pe     = (($countones(d) + int'(pbit)) % 2) != 0;
        f_pe_odd = !f_pe;
        f_fe     = !sbit;
        gap(gmax, rmode, 1'b1);
        step(1'b1, sbit, (rstop >= 0) ? bit'(rstop) : pick_rdy(rmode), 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b1; out_ready = 1'b0;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Clean even-parity frame, then bad parity bit, then bad stop bit.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1, -1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 0, 1, -1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1, -1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Back-to-back frames with no consumer: second is dropped.
        send_frame(8'h11, 1'b0, 1'b1, 0, 0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Completion coinciding with acceptance of the held word.
        do_reset();
        send_frame(8'h55, 1'b0, 1'b1, 0, 0, 0, 0);
        send_frame(8'h77, 1'b0, 1'b1, 0, 0, 1, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Gapped frame cut by reset, then the same word cleanly.
        send_frame(8'hC3, 1'b0, 1'b1, 3, 2, -1, 4);
        send_frame(8'hC3, 1'b0, 1'b1, 3, 1, -1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Random frames, gaps and consumer back-pressure.
        for (int unsigned k = 0; k < 40; k++) begin
            send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), 3, 2, -1, 0);
            repeat ($urandom_range(0, 2)) step(1'b1, 1'b1, pick_rdy(2), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
Serial frame receiver. It deserialises a bit-strobed frame (start, DATA_W data bits LSB-first, parity, stop), checks parity by XOR accumulation, and presents the word on a valid/ready output with a one-entry holding register. It is the receiving end of the codebase's serial parity link and sits between a bit-level line interface and a parallel consumer.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 1..32)
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
bit_valid  input  1  qualifies bit_in for one cycle; sampled only when high
bit_in  input  1  serial line bit; line idles at 1
out_data  output  DATA_W  received word; stable while out_valid=1
out_valid  output  1  holding register contains a word
out_ready  input  1  consumer accepts the word when out_valid & out_ready
parity_err  output  1  sideband of the held word: parity mismatch
frame_err  output  1  sideband of the held word: stop bit was 0
overrun  output  1  sticky; set when a frame completes while the holding register is full and not being drained that cycle
busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; bit counter 0; shift register 0; parity accumulator 0.
- Only cycles with bit_valid=1 advance the FSM. Cycles with bit_valid=0 hold all frame state.
- FSM states and transitions:
  - IDLE: bit_valid & bit_in=0 (start bit) -> DATA; counter := 0; accumulator := 0. bit_valid & bit_in=1 -> stay in IDLE.
  - DATA: shift bit_in into position [counter] (LSB first). accumulator ^= bit_in. counter++. When counter = DATA_W-1 and the bit is taken -> PARITY.
  - PARITY: capture perr = accumulator ^ bit_in ^ PARITY_ODD. A nonzero result is an error. -> STOP.
  - STOP: frame completes. fe = ~bit_in. -> IDLE. A stop bit of 0 is not reinterpreted as a new start bit.
- Completion and holding register:
  - On completion, if out_valid=0, or out_valid & out_ready in the same cycle: load out_data, parity_err := perr, frame_err := fe, out_valid := 1 on the next edge.
  - Otherwise the new frame is dropped, the held word is unchanged, and overrun := 1.
- Handshake: out_valid & out_ready with no simultaneous completion -> out_valid := 0 next cycle. out_data, parity_err and frame_err hold their last values (don't-care while out_valid=0).
- Latency: out_valid rises in the cycle after the stop-bit strobe.
- overrun clears only on rst.
- Reset mid-frame: the partial frame is discarded. A held word is cleared (out_valid := 0).
- Counter width: $clog2(DATA_W) bits, minimum 1. There is no wrap-around beyond DATA_W-1.

Decomposition:
- Package parity_frame_pkg:
  - rx_state_t enum {IDLE, DATA, PARITY, STOP}, 2 bits.
  - Function parity_of(logic [31:0] v, int n) for bench reference use.
- One sub-module, xor_accum: 1-bit registered XOR accumulator with clr and en inputs. It is instantiated once for the running parity.

Test Plan:
1. Even parity, DATA_W=8. Frame 0, then bits of 8'hA5 LSB-first, parity 0, stop 1, each bit with bit_valid=1; out_ready=1 -> out_data=8'hA5, out_valid pulses 1 cycle after the stop strobe, parity_err=0, frame_err=0.
2. Same frame with the parity bit set to 1 -> out_data=8'hA5, parity_err=1. With PARITY_ODD=1 and parity bit 1 -> parity_err=0.
3. Stop bit 0 on the 8'h3C frame -> frame_err=1. The FSM returns to IDLE and the next cycle's bit_in=1 keeps busy=0.
4. out_ready=0, two back-to-back frames 8'h11 then 8'h22 -> out_data stays 8'h11, overrun=1. Then out_ready=1 -> out_valid drops, overrun stays 1.
5. Completion of 8'h77 in the same cycle as acceptance of held 8'h55 -> out_valid stays 1, out_data=8'h77, overrun=0.
6. Gaps of 0–3 idle cycles (bit_valid=0) between bits of 8'hC3, plus rst asserted after the 4th data bit -> all outputs 0, busy=0. A subsequent clean 8'hC3 frame is received correctly.
